// File: rtl/ux607_sram_2port_arb_pkg.sv
// ux607_sram_2port_arb_pkg: port-index encoding and width helper for the SRAM 2-port arbiter
package ux607_sram_2port_arb_pkg;
  typedef enum logic {PORT_CORE = 1'b0, PORT_DMA = 1'b1} port_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ux607_arb_tag_fifo.sv
// ux607_arb_tag_fifo: in-order FIFO of granted port indices for outstanding commands
module ux607_arb_tag_fifo
  import ux607_sram_2port_arb_pkg::*;
#(
  parameter int DP = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  port_e i_data,
  input  logic  i_pop,
  output port_e o_head,
  output logic  o_full,
  output logic  o_empty
);
  localparam int PW = (DP > 1) ? clog2(DP) : 1;
  localparam int CW = clog2(DP + 1);
  port_e          r_mem [DP];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_cnt;
  // tag storage, written at the write pointer on push
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end
  // pointers wrap at DP; count tracks push minus pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= (r_wptr == PW'(DP - 1)) ? '0 : r_wptr + PW'(1);
      if (i_pop)  r_rptr <= (r_rptr == PW'(DP - 1)) ? '0 : r_rptr + PW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_cnt == CW'(DP));
  assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/ux607_sram_2port_arb.sv
// ux607_sram_2port_arb: shares one SRAM uop cmd/rsp channel between core LSU (p0) and DMA (p1)
module ux607_sram_2port_arb
  import ux607_sram_2port_arb_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int AW         = 32,
  parameter int USR_W      = 3,
  parameter int OUTS_DP    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_cmd_valid,
  output logic             p0_cmd_ready,
  input  logic             p0_cmd_read,
  input  logic [AW-1:0]    p0_cmd_addr,
  input  logic [DW-1:0]    p0_cmd_wdata,
  input  logic [MW-1:0]    p0_cmd_wmask,
  input  logic [1:0]       p0_cmd_size,
  input  logic [USR_W-1:0] p0_cmd_usr,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic             p0_rsp_err,
  output logic [DW-1:0]    p0_rsp_rdata,
  output logic [USR_W-1:0] p0_rsp_usr,
  input  logic             p1_cmd_valid,
  output logic             p1_cmd_ready,
  input  logic             p1_cmd_read,
  input  logic [AW-1:0]    p1_cmd_addr,
  input  logic [DW-1:0]    p1_cmd_wdata,
  input  logic [MW-1:0]    p1_cmd_wmask,
  input  logic [1:0]       p1_cmd_size,
  input  logic [USR_W-1:0] p1_cmd_usr,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic             p1_rsp_err,
  output logic [DW-1:0]    p1_rsp_rdata,
  output logic [USR_W-1:0] p1_rsp_usr,
  output logic             o_cmd_valid,
  input  logic             o_cmd_ready,
  output logic             o_cmd_read,
  output logic [AW-1:0]    o_cmd_addr,
  output logic [DW-1:0]    o_cmd_wdata,
  output logic [MW-1:0]    o_cmd_wmask,
  output logic [1:0]       o_cmd_size,
  output logic [USR_W-1:0] o_cmd_usr,
  input  logic             o_rsp_valid,
  output logic             o_rsp_ready,
  input  logic             o_rsp_err,
  input  logic [DW-1:0]    o_rsp_rdata,
  input  logic [USR_W-1:0] o_rsp_usr,
  output logic             arb_active
);
  localparam int SW = clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;
  logic          w_prio1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  port_e         w_head;
  assign w_prio1 = (r_starve == SW'(STARVE_MAX));
  assign w_gnt1  = p1_cmd_valid & (~p0_cmd_valid | w_prio1);
  assign w_gnt0  = p0_cmd_valid & ~w_gnt1;
  // readies ignore a same-cycle pop so no combinational path runs from rsp_ready to cmd_ready
  assign o_cmd_valid  = rst_n & (p0_cmd_valid | p1_cmd_valid) & ~w_full;
  assign p0_cmd_ready = rst_n & w_gnt0 & o_cmd_ready & ~w_full;
  assign p1_cmd_ready = rst_n & w_gnt1 & o_cmd_ready & ~w_full;
  assign o_cmd_read   = w_gnt1 ? p1_cmd_read  : p0_cmd_read;
  assign o_cmd_addr   = w_gnt1 ? p1_cmd_addr  : p0_cmd_addr;
  assign o_cmd_wdata  = w_gnt1 ? p1_cmd_wdata : p0_cmd_wdata;
  assign o_cmd_wmask  = w_gnt1 ? p1_cmd_wmask : p0_cmd_wmask;
  assign o_cmd_size   = w_gnt1 ? p1_cmd_size  : p0_cmd_size;
  assign o_cmd_usr    = w_gnt1 ? p1_cmd_usr   : p0_cmd_usr;
  assign w_push = o_cmd_valid & o_cmd_ready;
  assign w_pop  = o_rsp_valid & o_rsp_ready;
  ux607_arb_tag_fifo #(.DP(OUTS_DP)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (port_e'(w_gnt1)),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign p0_rsp_valid = o_rsp_valid & ~w_empty & (w_head == PORT_CORE);
  assign p1_rsp_valid = o_rsp_valid & ~w_empty & (w_head == PORT_DMA);
  assign o_rsp_ready  = ~w_empty & ((w_head == PORT_DMA) ? p1_rsp_ready : p0_rsp_ready);
  assign p0_rsp_err   = o_rsp_err;
  assign p1_rsp_err   = o_rsp_err;
  assign p0_rsp_rdata = o_rsp_rdata;
  assign p1_rsp_rdata = o_rsp_rdata;
  assign p0_rsp_usr   = o_rsp_usr;
  assign p1_rsp_usr   = o_rsp_usr;
  assign arb_active   = p0_cmd_valid | p1_cmd_valid | ~w_empty;
  // count cycles port 1 waits; saturate so priority holds until it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else r_starve <= (p1_cmd_valid & ~p1_cmd_ready) ? (w_prio1 ? r_starve : r_starve + SW'(1)) : '0;
  end
  // a response with no outstanding tag has nowhere to go
  a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n) !(o_rsp_valid && w_empty));
endmodule
